// File: rtl/tile_line_fetcher_if.sv
// Fetcher-side bundle: start/line control, RAM address/data bus and the display pixel read port.
interface tile_line_fetcher_if #(
  parameter int Bits = 16
);
  logic            start;
  logic [7:0]      line;
  logic            busy;
  logic            done;
  logic [Bits-1:0] memAddress;
  logic            memActive;
  logic [7:0]      memData;
  logic [7:0]      pixX;
  logic [3:0]      pixel;

  modport master (
    input  start, line, memData, pixX,
    output busy, done, memAddress, memActive, pixel
  );

  modport slave (
    output start, line, memData, pixX,
    input  busy, done, memAddress, memActive, pixel
  );
endinterface

// File: rtl/tile_line_fetcher.sv
// Scanline tile fetcher into a double-buffered 256x4bpp line buffer; pixel read has 1-cycle latency.
// No backpressure: owns the RAM bus while busy and ignores start until idle. TILE_FLIP_EN enables attribute H/V flips.
module tile_line_fetcher #(
  parameter int Bits     = 16,
  parameter int MapBase  = 0,
`ifdef TILE_FLIP_EN
  parameter int AttrBase = 1024,
`endif
  parameter int PatBase  = 8192
) (
  input logic                 clk,
  input logic                 reset,
  tile_line_fetcher_if.master bus
);

`ifdef TILE_FLIP_EN
  typedef enum logic [2:0] {IDLE, MAP, ATTR, PAT, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, MAP, PAT, FINISH} state_t;
`endif

  state_t          state;
  logic [4:0]      row;
  logic [4:0]      col;
  logic [2:0]      fine;
  logic [1:0]      b;
  logic [7:0]      tile;
  logic            flip_v;
  logic            flip_h;
  logic            fsel;
  logic            busy;
  logic            done;
  logic            mem_active;
  logic [Bits-1:0] mem_addr;
  logic [3:0]      pixel;

  // Each entry holds a left/right pixel pair; bit 8 of the index selects the buffer half.
  logic [7:0]      lbuf [512];

  logic            wr_en;
  logic [8:0]      wr_idx;
  logic [7:0]      wr_byte;
  logic            fsel_nxt;
  logic [7:0]      rd_byte;

  function automatic logic [Bits-1:0] map_addr(input logic [4:0] r, input logic [4:0] c);
    return Bits'(MapBase) + Bits'({r, c});
  endfunction

`ifdef TILE_FLIP_EN
  function automatic logic [Bits-1:0] attr_addr(input logic [4:0] r, input logic [4:0] c);
    return Bits'(AttrBase) + Bits'({r, c});
  endfunction
`endif

  function automatic logic [Bits-1:0] pat_addr(input logic [7:0] t, input logic [2:0] fy_in,
                                               input logic fv, input logic fh, input logic [1:0] bb);
    logic [2:0] fy;
    logic [1:0] sb;
    fy = fv ? ~fy_in : fy_in;
    sb = fh ? ~bb : bb;
    return Bits'(PatBase) + Bits'({t, fy, sb});
  endfunction

`ifndef TILE_FLIP_EN
  assign flip_v = 1'b0;
  assign flip_h = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_active <= 1'b0;
      mem_addr   <= '0;
      fsel       <= 1'b0;
      row        <= '0;
      fine       <= '0;
      col        <= '0;
      b          <= '0;
      tile       <= '0;
`ifdef TILE_FLIP_EN
      flip_v     <= 1'b0;
      flip_h     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            fsel       <= ~fsel;
            row        <= bus.line[7:3];
            fine       <= bus.line[2:0];
            col        <= '0;
            mem_addr   <= map_addr(bus.line[7:3], 5'd0);
            busy       <= 1'b1;
            mem_active <= 1'b1;
            state      <= MAP;
          end
        end
        MAP: begin
          tile <= bus.memData;
`ifdef TILE_FLIP_EN
          mem_addr <= attr_addr(row, col);
          state    <= ATTR;
`else
          b        <= '0;
          mem_addr <= pat_addr(bus.memData, fine, 1'b0, 1'b0, 2'd0);
          state    <= PAT;
`endif
        end
`ifdef TILE_FLIP_EN
        ATTR: begin
          flip_v   <= bus.memData[7];
          flip_h   <= bus.memData[6];
          b        <= '0;
          // The first pattern address needs the flips now, before they land in flip_v/flip_h.
          mem_addr <= pat_addr(tile, fine, bus.memData[7], bus.memData[6], 2'd0);
          state    <= PAT;
        end
`endif
        PAT: begin
          if (b == 2'd3) begin
            if (col == 5'd31) begin
              done       <= 1'b1;
              busy       <= 1'b0;
              mem_active <= 1'b0;
              mem_addr   <= '0;
              state      <= FINISH;
            end else begin
              col      <= col + 5'd1;
              mem_addr <= map_addr(row, col + 5'd1);
              state    <= MAP;
            end
          end else begin
            b        <= b + 2'd1;
            mem_addr <= pat_addr(tile, fine, flip_v, flip_h, b + 2'd1);
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en   = reset && (state == PAT);
    wr_idx  = {~fsel, col, b};
    wr_byte = flip_h ? {bus.memData[3:0], bus.memData[7:4]} : bus.memData;
  end

  // Line buffer contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lbuf[wr_idx] <= wr_byte;
    end
  end

  // A start accepted on this edge already redirects the read to the new front buffer.
  always_comb begin
    fsel_nxt = (state == IDLE && bus.start) ? ~fsel : fsel;
    rd_byte  = lbuf[{fsel_nxt, bus.pixX[7:1]}];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel <= '0;
    end else begin
      pixel <= bus.pixX[0] ? rd_byte[3:0] : rd_byte[7:4];
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.memAddress = mem_addr;
  assign bus.memActive  = mem_active;
  assign bus.pixel      = pixel;

  a_done_pulse: assert property (@(posedge clk) disable iff (!reset) done |=> !done);
  a_idle_addr:  assert property (@(posedge clk) disable iff (!reset) !mem_active |-> mem_addr == '0);
  a_busy_bus:   assert property (@(posedge clk) disable iff (!reset) busy == mem_active);

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Directed bench for tile_line_fetcher: queue-based pixel and done scoreboards drained by a monitor.
module tb_tile_line_fetcher;

`ifdef TILE_FLIP_EN
  localparam int LINE_CYC   = 192;
  localparam int SECOND_ADR = 1024;
  localparam int COL1_PAT   = 8;
  localparam int COL1_ADR   = 8255;
`else
  localparam int LINE_CYC   = 160;
  localparam int SECOND_ADR = 8192;
  localparam int COL1_PAT   = 6;
  localparam int COL1_ADR   = 8224;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tile_line_fetcher_if #(.Bits(16)) bus();

  tile_line_fetcher #(.Bits(16), .MapBase(0), .PatBase(8192)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] ram [65536];
  assign bus.memData = ram[bus.memAddress];

  // Hand-unpacked rows: tile0 row0, tile0 row1, tile1 row0, tile1 row7 flipped, tile2 row1.
  logic [3:0] pa0 [8] = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0};
  logic [3:0] pb0 [8] = '{4'hA, 4'h5, 4'h5, 4'hA, 4'h0, 4'h0, 4'hF, 4'hF};
`ifdef TILE_FLIP_EN
  logic [3:0] pt1 [8] = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
`else
  logic [3:0] pt1 [8] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
`endif
  logic [3:0] pb2 [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};

  function automatic logic [3:0] exp_a(input int x);
    if (x < 8)  return pa0[x];
    if (x < 16) return pt1[x - 8];
    return pa0[x % 8];
  endfunction

  function automatic logic [3:0] exp_b(input int x);
    if (x < 8) return pb2[x];
    return pb0[x % 8];
  endfunction

  typedef struct {
    int         x;
    logic [3:0] val;
  } rd_t;

  rd_t  exp_q[$];
  int   done_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic rd_vld      = 1'b0;
  logic mon_rd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic rd(input int x, input logic [3:0] v);
    rd_t e;
    bus.pixX = 8'(x);
    e.x      = x;
    e.val    = v;
    exp_q.push_back(e);
    rd_vld   = 1'b1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done within 400 cycles required one");
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    rd_t e;
    int  want;
    cyc    = cyc + 1;
    mon_rd = rd_vld;
    #1;
    if (mon_rd === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pixel_unexpected: got read with empty queue required expectation");
      end else begin
        e = exp_q.pop_front();
        if (bus.pixel !== e.val) begin
          miscompares++;
          $display("FAIL pixel x=%0d: got %0h required %0h", e.x, bus.pixel, e.val);
        end
      end
    end
    if (bus.done === 1'b1) begin
      vectors++;
      if (done_q.size() == 0) begin
        miscompares++;
        $display("FAIL done_unexpected: got done at cycle %0d required none", cyc);
      end else begin
        want = done_q.pop_front();
        if (cyc != want) begin
          miscompares++;
          $display("FAIL done_cycle: got %0d required %0d", cyc, want);
        end
      end
    end
  end

  initial begin
    bus.start = 1'b1;
    bus.line  = 8'd0;
    bus.pixX  = 8'd0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[1]    = 8'h01;
    ram[32]   = 8'h02;
    ram[1025] = 8'hC0;
    ram[8192] = 8'h08; ram[8193] = 8'h80; ram[8194] = 8'h08; ram[8195] = 8'h80;
    ram[8196] = 8'hA5; ram[8197] = 8'h5A; ram[8198] = 8'h00; ram[8199] = 8'hFF;
    ram[8224] = 8'h9A; ram[8225] = 8'hBC; ram[8226] = 8'hDE; ram[8227] = 8'hF0;
    ram[8252] = 8'h12; ram[8253] = 8'h34; ram[8254] = 8'h56; ram[8255] = 8'h78;
    ram[8260] = 8'h11; ram[8261] = 8'h22; ram[8262] = 8'h33; ram[8263] = 8'h44;

    // Reset held with start asserted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_addr", 32'(bus.memAddress), 0);
      chk("rst_active", 32'(bus.memActive), 0);
      chk("rst_pixel", 32'(bus.pixel), 0);
    end
    reset     = 1'b1;
    bus.start = 1'b0;

    // Line A (line 0): address sequence and done timing.
    @(negedge clk);
    bus.line  = 8'd0;
    bus.start = 1'b1;
    done_q.push_back(cyc + 1 + LINE_CYC);
    for (int k = 1; k <= COL1_PAT + 1; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 1) begin
        chk("a_busy", 32'(bus.busy), 1);
        chk("a_active", 32'(bus.memActive), 1);
        chk("a_map_addr", 32'(bus.memAddress), 0);
      end
      if (k == 2) chk("a_second_addr", 32'(bus.memAddress), SECOND_ADR);
      if (k == COL1_PAT + 1) chk("a_col1_pat_addr", 32'(bus.memAddress), COL1_ADR);
    end
    wait_done();

    // Line B (line 9): sweep the front (A) during the fetch; stray start at cycle 50.
    @(negedge clk);
    bus.line  = 8'd9;
    bus.start = 1'b1;
    done_q.push_back(cyc + 1 + LINE_CYC);
    rd(0, exp_a(0));
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      bus.start = (i == 50);
      if (i == 1) chk("b_busy", 32'(bus.busy), 1);
      rd(i, exp_a(i));
    end
    @(negedge clk);
    rd_vld    = 1'b0;
    bus.start = 1'b0;
    chk("b_idle_busy", 32'(bus.busy), 0);

    // Line C (line 248): swap to B, reset at cycle ~100 with start asserted.
    @(negedge clk);
    bus.line  = 8'd248;
    bus.start = 1'b1;
    rd(3, exp_b(3));
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 1) begin
        chk("c_map_addr_row31", 32'(bus.memAddress), 992);
        chk("c_busy", 32'(bus.busy), 1);
      end
      if (k < 16) rd(k, exp_b(k));
      else rd_vld = 1'b0;
    end
    reset     = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_active", 32'(bus.memActive), 0);
    chk("mid_rst_addr", 32'(bus.memAddress), 0);
    chk("mid_rst_pixel", 32'(bus.pixel), 0);
    reset     = 1'b1;
    bus.start = 1'b0;

    // Line D after reset: select goes to 1, so the front is B again.
    @(negedge clk);
    bus.line  = 8'd0;
    bus.start = 1'b1;
    done_q.push_back(cyc + 1 + LINE_CYC);
    rd(8, exp_b(8));
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 1) chk("d_busy", 32'(bus.busy), 1);
      rd(k, exp_b(k));
    end
    @(negedge clk);
    rd_vld = 1'b0;
    wait_done();

    // Line E: the front becomes D's line-0 contents.
    @(negedge clk);
    bus.line  = 8'd9;
    bus.start = 1'b1;
    done_q.push_back(cyc + 1 + LINE_CYC);
    rd(0, exp_a(0));
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      rd(k, exp_a(k));
    end
    @(negedge clk);
    rd_vld = 1'b0;
    wait_done();

    repeat (3) @(negedge clk);
    chk("done_q_drained", 32'(done_q.size()), 0);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tile_line_fetcher.md
Name: tile_line_fetcher

Overview:
- Video front-end stage directly downstream of the 64 KB RAM.
- Per scanline: walks the 32-column tilemap, reads each tile's attribute byte and its 4 bytes of 4bpp pattern data, and unpacks them into a double-buffered 256-pixel line buffer.
- The display side reads 4-bit colour indices by X position from the front buffer while the next line fills the back buffer.

Parameters:
- Bits, 16, RAM address width; matches the RAM's Bits.
- MapBase, 0, byte address of the 32x32 tilemap (one tile index per byte).
- AttrBase, 1024, byte address of the 32x32 attribute map; bit7 = flip V, bit6 = flip H, bits 5:0 ignored.
- PatBase, 8192, byte address of pattern data; 32 bytes per tile, 4 bytes per row, high nibble = left pixel.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: swap buffers and begin fetching line `line`.
- line  in  8  scanline 0..255; bits 7:3 = tile row, bits 2:0 = fine Y.
- busy  out  1  high while fetching.
- done  out  1  one-cycle pulse when the last pattern byte of column 31 is written.
- memAddress  out  Bits  RAM address; holds 0 when idle.
- memActive  out  1  high while the fetcher owns the RAM address bus.
- memData  in  8  RAM dataOut; asynchronous read, sampled on the same edge the address is presented.
- pixX  in  8  display X position.
- pixel  out  4  colour index of front buffer[pixX], registered, 1-cycle latency.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State returns to IDLE.
  - busy=0, done=0, memActive=0, memAddress=0, pixel=0.
  - Front-buffer select goes to 0.
  - Buffer contents are not cleared.
  - Reset wins over start on the same edge, including mid-line.
- States: IDLE, MAP, ATTR, PAT, FINISH.
- IDLE:
  - On start: toggle the front/back select, latch `line`, set col=0, enter MAP.
  - busy rises the cycle after start.
- MAP: memAddress = MapBase + row*32 + col; latch tile index; go to ATTR.
- ATTR: memAddress = AttrBase + row*32 + col; latch flipV/flipH; go to PAT with byte counter b=0.
- PAT:
  - fy = flipV ? 7-fineY : fineY.
  - Source byte index sb = flipH ? 3-b : b.
  - memAddress = PatBase + tile*32 + fy*4 + sb, computed in Bits width; wraps modulo 2^Bits.
  - Data byte {hi,lo} is written to back buffer pixels col*8+2b and col*8+2b+1.
    - Normal: (hi, lo).
    - flipH: (lo, hi).
  - b=3 with col<31: col++, back to MAP. b=3 with col=31: go to FINISH.
- FINISH: done=1 for one cycle, busy=0, memActive=0, return to IDLE.
- Timing: 6 cycles per tile; line fetch takes exactly 192 cycles from the first MAP cycle to the FINISH cycle.
- start while busy: ignored; no swap, no restart.
- The pixel read port is independent of the fetch. It always reads the front buffer; the back buffer is never visible.
- A swap takes effect on the edge that accepts start. A pixX presented in the same cycle already reads the new front buffer on the next edge.
- Tile row 31 at line 248..255 addresses map bytes 992..1023; no wrap into attributes.

Optional Feature:
- Macro: TILE_FLIP_EN.
- Defined: behaviour as above (ATTR state present, flips honoured, 6 cycles/tile, 192 cycles/line).
- Undefined:
  - ATTR state removed; MAP goes directly to PAT.
  - flipV=flipH=0 always; AttrBase is unused.
  - 5 cycles/tile, 160 cycles/line; done pulses 160 cycles after the first MAP cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> busy=0, done=0, memAddress=0, pixel=0.
- Map[0]=0, attr 0, pattern tile 0 row 0 = 08 80 08 80; start with line=0 -> front pixels 0..7 = 0,8,8,0,0,8,8,0; done exactly 192 cycles after the first MAP cycle.
- Map[1]=1, attr[1025]=0xC0, tile 1 row 7 bytes = 12 34 56 78; line=0 -> pixels 8..15 = 8,7,6,5,4,3,2,1 (V flip selects row 7, H flip reverses order).
- Double buffer: fill line A, start line B; while fetching B, sweep pixX 0..255 -> pixel matches A, with 1-cycle latency throughout.
- start pulsed at cycle 50 of a fetch -> ignored; done arrives once at cycle 192; then start again -> swap occurs.
- Drop reset at cycle 100 mid-fetch, then start -> clean 192-cycle fetch, front select = 1 after the start. Without TILE_FLIP_EN, the same stimulus gives a 160-cycle fetch and the 0xC0 attribute is ignored.
